instr_fetch_queue: RTL and testbench

- Prefetch stage directly upstream of the microprocessor's fetch/decode pipeline.
- Issues sequential 12-bit instruction reads to instruction memory over a req/ack handshake and buffers the returned words in a small FIFO.
- Presents instructions to fetch/decode with valid/ready, each tagged with its 7-bit PC.
- Supports redirect (flush), skip-next (for SPA/SNA/SZA/SZE/ISZ) and halt.

---
 rtl/instr_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: sequential req/ack reads from instruction memory into a
// show-ahead FIFO of {instr, pc}, with flush/redirect, skip-next and halt.
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 7,
  parameter int INSTR_W = 12
) (
  input  logic               clk1,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_adr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  input  logic               skip,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  input  logic               halt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fpc_q, fpc_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic               req_q;
  logic               valid_q;
  logic               skip_pend_q, skip_pend_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];

  logic ack_req;
  logic drop;
  logic wr;
  logic pop;
  logic issue;

  assign imem_req  = req_q;
  assign imem_adr  = adr_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];

  // A skip that finds the FIFO empty consumes the word arriving on the same edge.
  assign ack_req = imem_ack && (state_q == REQ);
  assign drop    = skip_pend_q || (skip && !valid_q);
  assign wr      = ack_req && !drop;
  assign pop     = valid_q && (out_ready || skip);

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    adr_d       = adr_q;
    skip_pend_d = skip_pend_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    issue       = 1'b0;
    if (flush) begin
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      skip_pend_d = 1'b0;
      fpc_d       = flush_pc;
      state_d     = ((state_q != IDLE) && !imem_ack) ? DRAIN : IDLE;
    end else begin
      if (wr)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr) - CNT_W'(pop);
      if (ack_req) begin
        fpc_d       = fpc_q + ADDR_W'(1);
        skip_pend_d = 1'b0;
      end else if (skip && !valid_q) begin
        skip_pend_d = 1'b1;
      end
      issue = !halt && (count_d < CNT_W'(DEPTH));
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_d = REQ;
            adr_d   = fpc_q;
          end
        end
        REQ: begin
          if (imem_ack) begin
            state_d = issue ? REQ : IDLE;
            if (issue) adr_d = fpc_d;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state_d = issue ? REQ : IDLE;
            if (issue) adr_d = fpc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      fpc_q       <= '0;
      adr_q       <= '0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      skip_pend_q <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      adr_q       <= adr_d;
      req_q       <= (state_d != IDLE);
      valid_q     <= (count_d != '0);
      skip_pend_q <= skip_pend_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      if (!flush && wr) begin
        instr_q[wr_ptr_q] <= imem_data;
        pc_q[wr_ptr_q]    <= adr_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a memory responder returning 0xA00+addr.
module tb_instr_fetch_queue;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [6:0]  imem_adr;
  logic        imem_ack;
  logic [11:0] imem_data;
  logic        out_valid;
  logic [11:0] out_instr;
  logic [6:0]  out_pc;
  logic        out_ready;
  logic        skip;
  logic        flush;
  logic [6:0]  flush_pc;
  logic        halt;

  int checkCount = 0;
  int errorCount = 0;

  // One address can be made slow to answer; slowLat=0 means every access is zero-wait.
  logic [6:0] slowAdr;
  int         slowLat;
  int         waitCnt;

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(7), .INSTR_W(12)) dut (
    .clk1(clk1), .rst(rst),
    .imem_req(imem_req), .imem_adr(imem_adr), .imem_ack(imem_ack), .imem_data(imem_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .skip(skip), .flush(flush), .flush_pc(flush_pc), .halt(halt)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    if (!imem_req) begin
      imem_ack = 1'b0;
      waitCnt  = 0;
    end else begin
      if (imem_ack) waitCnt = 0;
      if (waitCnt >= ((imem_adr == slowAdr) ? slowLat : 0)) begin
        imem_ack  = 1'b1;
        imem_data = 12'hA00 + {5'b0, imem_adr};
      end else begin
        imem_ack = 1'b0;
        waitCnt++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic sk, input logic fl,
                               input logic [6:0] fpc, input logic hl);
    out_ready = rdy;
    skip      = sk;
    flush     = fl;
    flush_pc  = fpc;
    halt      = hl;
  endtask

  // Leaves rst low just after an edge, so the next tick is the first active edge.
  task automatic applyReset(input logic rdy);
    rst = 1'b1;
    applyStimulus(rdy, 1'b0, 1'b0, 7'd0, 1'b0);
    tick(2);
    checkOutput("rst_req",   imem_req,  0);
    checkOutput("rst_adr",   imem_adr,  0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_instr", out_instr, 0);
    checkOutput("rst_pc",    out_pc,    0);
    rst = 1'b0;
  endtask

  initial begin
    imem_ack  = 1'b0;
    imem_data = '0;
    waitCnt   = 0;
    slowAdr   = 7'd0;
    slowLat   = 0;

    // Streaming with wrap at 127
    applyReset(1'b1);
    tick();
    checkOutput("first_req", imem_req, 1);
    checkOutput("first_adr", imem_adr, 0);
    checkOutput("first_valid", out_valid, 0);
    for (int k = 0; k < 132; k++) begin
      tick();
      checkOutput("stream_valid", out_valid, 1);
      checkOutput("stream_pc",    out_pc,    k % 128);
      checkOutput("stream_instr", out_instr, 12'hA00 + (k % 128));
    end

    // Backpressure: four entries then fetch stops
    applyReset(1'b0);
    tick(10);
    checkOutput("bp_req",   imem_req, 0);
    checkOutput("bp_valid", out_valid, 1);
    checkOutput("bp_pc0",   out_pc, 0);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_pc1",   out_pc, 1);
    checkOutput("bp_resreq", imem_req, 1);
    checkOutput("bp_resadr", imem_adr, 4);
    for (int k = 2; k < 6; k++) begin
      tick();
      checkOutput("bp_drain_pc", out_pc, k);
    end

    // Flush while pc=5 is waiting on memory
    slowAdr = 7'd5;
    slowLat = 3;
    applyReset(1'b1);
    tick(7);
    checkOutput("fl_pre_valid", out_valid, 0);
    checkOutput("fl_pre_adr",   imem_adr, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd40, 1'b0);
    tick();
    flush = 1'b0;
    checkOutput("fl_drain_req", imem_req, 1);
    checkOutput("fl_drain_adr", imem_adr, 5);
    checkOutput("fl_drain_valid", out_valid, 0);
    tick();
    checkOutput("fl_wait_valid", out_valid, 0);
    tick();
    checkOutput("fl_new_adr",   imem_adr, 40);
    checkOutput("fl_new_valid", out_valid, 0);
    tick();
    checkOutput("fl_valid", out_valid, 1);
    checkOutput("fl_pc",    out_pc, 40);
    checkOutput("fl_instr", out_instr, 12'hA28);
    slowLat = 0;

    // Skip with head pc=7
    applyReset(1'b1);
    tick(9);
    checkOutput("sk_head7", out_pc, 7);
    applyStimulus(1'b0, 1'b1, 1'b0, 7'd0, 1'b0);
    tick();
    skip = 1'b0;
    checkOutput("sk_head8", out_pc, 8);
    checkOutput("sk_valid8", out_valid, 1);

    // Skip with the FIFO empty while pc=2 is slow
    slowAdr = 7'd2;
    slowLat = 3;
    applyReset(1'b1);
    tick(4);
    checkOutput("ske_empty", out_valid, 0);
    skip = 1'b1;
    tick();
    skip = 1'b0;
    tick(2);
    checkOutput("ske_dropped", out_valid, 0);
    tick();
    checkOutput("ske_valid", out_valid, 1);
    checkOutput("ske_pc",    out_pc, 3);
    checkOutput("ske_instr", out_instr, 12'hA03);
    slowLat = 0;

    // Halt with pc=3 pending
    slowAdr = 7'd3;
    slowLat = 2;
    applyReset(1'b1);
    tick(5);
    checkOutput("h_pend_adr", imem_adr, 3);
    halt = 1'b1;
    tick(2);
    checkOutput("h_valid", out_valid, 1);
    checkOutput("h_pc3",   out_pc, 3);
    checkOutput("h_req0",  imem_req, 0);
    tick(2);
    checkOutput("h_req_still0", imem_req, 0);
    halt = 1'b0;
    tick();
    checkOutput("h_resume_req", imem_req, 1);
    checkOutput("h_resume_adr", imem_adr, 4);
    tick();
    checkOutput("h_pc4", out_pc, 4);
    slowLat = 0;

    // Flush + skip + out_ready together, then reset mid-stream
    applyReset(1'b1);
    tick(5);
    checkOutput("sim_head3", out_pc, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 7'd100, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
    checkOutput("sim_empty", out_valid, 0);
    checkOutput("sim_req0",  imem_req, 0);
    tick();
    checkOutput("sim_req",  imem_req, 1);
    checkOutput("sim_adr",  imem_adr, 100);
    tick();
    checkOutput("sim_valid", out_valid, 1);
    checkOutput("sim_pc",    out_pc, 100);
    checkOutput("sim_instr", out_instr, 12'hA64);
    tick(3);
    checkOutput("mid_pc", out_pc, 103);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_req",   imem_req, 0);
    checkOutput("mid_rst_adr",   imem_adr, 0);
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_instr", out_instr, 0);
    checkOutput("mid_rst_pc",    out_pc, 0);
    rst = 1'b0;
    tick(2);
    checkOutput("mid_restart_valid", out_valid, 1);
    checkOutput("mid_restart_pc",    out_pc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
